fp_seq_divider: RTL

FP_SEQ_DIVIDER -- requirements
Module: fp_seq_divider

---
 rtl/fpdiv_pkg.sv | 33 +++
 rtl/fpdiv_unpack.sv | 32 +++
 rtl/fp_seq_divider.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpdiv_pkg.sv
// Shared constants for the sequential floating-point divider: state codes,
// default field widths, operand kinds and the bias / quiet-NaN helpers.
package fpdiv_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_PREP = 3'd1;
  localparam state_t S_ITER = 3'd2;
  localparam state_t S_NORM = 3'd3;
  localparam state_t S_DONE = 3'd4;

  // Outcome class decided in PREP; only K_NUM uses the iterated quotient.
  localparam logic [1:0] K_NUM  = 2'd0;
  localparam logic [1:0] K_INF  = 2'd1;
  localparam logic [1:0] K_ZERO = 2'd2;
  localparam logic [1:0] K_NAN  = 2'd3;

  function automatic int fpdiv_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] fpdiv_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fpdiv_unpack.sv
// Combinational operand classifier: splits an IEEE-style word into fields
// and flags zero (subnormals included), infinity and NaN.
module fpdiv_unpack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       mant_o,
  output logic                 isZero_o,
  output logic                 isInf_o,
  output logic                 isNan_o
);

  logic [MAN_W-1:0] frac;
  logic             expOnes;
  logic             fracZero;

  assign sign_o   = op_i[EXP_W+MAN_W];
  assign exp_o    = op_i[EXP_W+MAN_W-1:MAN_W];
  assign frac     = op_i[MAN_W-1:0];
  assign mant_o   = {1'b1, frac};
  assign expOnes  = &exp_o;
  assign fracZero = (frac == '0);

  // Subnormals are flushed: a zero exponent field always reads as zero.
  assign isZero_o = (exp_o == '0);
  assign isInf_o  = expOnes & fracZero;
  assign isNan_o  = expOnes & ~fracZero;

endmodule

// File: rtl/fp_seq_divider.sv
// Sequential floating-point divider: one restoring quotient bit per cycle,
// fixed MAN_W+5 latency. Define FPDIV_RNE_EN for round-to-nearest-even, else truncation.
module fp_seq_divider
  import fpdiv_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 dv_by_zero,
  output logic                 invalid
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int ITERS = MAN_W + 3;
  localparam int CW    = $clog2(ITERS);
  localparam int EW    = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS  = EW'(fpdiv_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EONE  = EW'(1);
  localparam logic signed [EW-1:0] EZERO = EW'(0);
  localparam logic [63:0]          QNAN_WIDE = fpdiv_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN      = QNAN_WIDE[W-1:0];

  state_t                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [MAN_W+1:0]      rem_q, rem_d;
  logic [MAN_W:0]        div_q, div_d;
  logic [MAN_W+2:0]      quot_q, quot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            kind_q, kind_d;
  logic                  dvzPend_q, dvzPend_d;
  logic [W-1:0]          result_q, result_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, dvz_q, dvz_d, inv_q, inv_d;

  logic                  aSign, bSign, aZero, bZero, aInf, bInf, aNan, bNan;
  logic [EXP_W-1:0]      aExp, bExp;
  logic [MAN_W:0]        aMant, bMant;

  fpdiv_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) uUnpackA (
    .op_i(a_q), .sign_o(aSign), .exp_o(aExp), .mant_o(aMant),
    .isZero_o(aZero), .isInf_o(aInf), .isNan_o(aNan)
  );

  fpdiv_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) uUnpackB (
    .op_i(b_q), .sign_o(bSign), .exp_o(bExp), .mant_o(bMant),
    .isZero_o(bZero), .isInf_o(bInf), .isNan_o(bNan)
  );

  logic [1:0] kindC;
  logic       dvzC;

  always_comb begin
    kindC = K_NUM;
    dvzC  = 1'b0;
    if (aNan | bNan | (aZero & bZero) | (aInf & bInf)) begin
      kindC = K_NAN;
    end else if (aInf) begin
      kindC = K_INF;
    end else if (bZero) begin
      kindC = K_INF;
      dvzC  = 1'b1;
    end else if (aZero | bInf) begin
      kindC = K_ZERO;
    end
  end

  // Restoring step: the remainder stays below twice the divisor, so MAN_W+2 bits suffice.
  logic             qBit;
  logic [MAN_W+1:0] remSub;

  always_comb begin
    if (rem_q >= {1'b0, div_q}) begin
      qBit   = 1'b1;
      remSub = rem_q - {1'b0, div_q};
    end else begin
      qBit   = 1'b0;
      remSub = rem_q;
    end
  end

  logic [MAN_W:0]       mantN;
  logic signed [EW-1:0] expN, expR;
  logic [MAN_W+1:0]     mantR;
  logic [MAN_W-1:0]     fracR;
  logic [W-1:0]         resC;
  logic                 ovfC, unfC, dvzOutC, invC;
`ifdef FPDIV_RNE_EN
  logic                 guardBit, roundBit, stickyBit, roundUp;
`endif

  always_comb begin
    if (quot_q[MAN_W+2]) begin
      mantN = quot_q[MAN_W+2:2];
      expN  = exp_q;
    end else begin
      mantN = quot_q[MAN_W+1:1];
      expN  = exp_q - EONE;
    end
`ifdef FPDIV_RNE_EN
    if (quot_q[MAN_W+2]) begin
      guardBit = quot_q[1];
      roundBit = quot_q[0];
    end else begin
      guardBit = quot_q[0];
      roundBit = 1'b0;
    end
    stickyBit = |rem_q;
    roundUp   = guardBit & (roundBit | stickyBit | mantN[0]);
    mantR     = {1'b0, mantN} + {{(MAN_W+1){1'b0}}, roundUp};
`else
    mantR     = {1'b0, mantN};
`endif
    if (mantR[MAN_W+1]) begin
      fracR = mantR[MAN_W:1];
      expR  = expN + EONE;
    end else begin
      fracR = mantR[MAN_W-1:0];
      expR  = expN;
    end

    resC    = '0;
    ovfC    = 1'b0;
    unfC    = 1'b0;
    dvzOutC = 1'b0;
    invC    = 1'b0;
    case (kind_q)
      K_NAN: begin
        resC = QNAN;
        invC = 1'b1;
      end
      K_INF: begin
        resC    = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        dvzOutC = dvzPend_q;
      end
      K_ZERO: resC = {sign_q, {(W-1){1'b0}}};
      default: begin
        if (expR >= EMAX) begin
          resC = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovfC = 1'b1;
        end else if (expR <= EZERO) begin
          resC = {sign_q, {(W-1){1'b0}}};
          unfC = 1'b1;
        end else begin
          resC = {sign_q, expR[EXP_W-1:0], fracR};
        end
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    rem_d     = rem_q;
    div_d     = div_q;
    quot_d    = quot_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    dvzPend_d = dvzPend_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    dvz_d     = dvz_q;
    inv_d     = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PREP;
          a_d     = a;
          b_d     = b;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          dvz_d   = 1'b0;
          inv_d   = 1'b0;
        end
      end
      S_PREP: begin
        state_d   = S_ITER;
        sign_d    = aSign ^ bSign;
        exp_d     = $signed({2'b00, aExp}) - $signed({2'b00, bExp}) + BIAS;
        rem_d     = {1'b0, aMant};
        div_d     = bMant;
        quot_d    = '0;
        cnt_d     = '0;
        kind_d    = kindC;
        dvzPend_d = dvzC;
      end
      S_ITER: begin
        rem_d  = remSub << 1;
        quot_d = {quot_q[MAN_W+1:0], qBit};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        state_d  = S_DONE;
        result_d = resC;
        ovf_d    = ovfC;
        unf_d    = unfC;
        dvz_d    = dvzOutC;
        inv_d    = invC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
      kind_q    <= K_NUM;
      dvzPend_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      dvz_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      quot_q    <= quot_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      dvzPend_q <= dvzPend_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      dvz_q     <= dvz_d;
      inv_q     <= inv_d;
    end
  end

  assign busy       = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_NORM);
  assign done       = (state_q == S_DONE);
  assign result     = result_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign dv_by_zero = dvz_q;
  assign invalid    = inv_q;

endmodule
